// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the floating-point add/multiply sequencer.
package fp_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXP,
        S_ALIGN,
        S_BIG,
        S_LD_EXP,
        S_NORM,
        S_LD_NORM,
        S_RND,
        S_LD_RND,
        S_CHK,
        S_LD_OVF,
        S_DONE
    } state_e;

    localparam logic OP_SOMA     = 1'b1;
    localparam logic OP_MULT     = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    localparam int unsigned MAX_ALIGN_DEFAULT = 26;

    // Subtract a single bit, saturating at zero instead of wrapping.
    function automatic logic [7:0] sub_clamp(input logic [7:0] a, input logic b);
        return (a >= {7'd0, b}) ? a - {7'd0, b} : 8'd0;
    endfunction

endpackage

// File: rtl/fp_control_unit.sv
// Moore sequencer driving the floating-point Datapath through one add or multiply.
// Outputs are registered from the next state so they are valid for the whole state.
module fp_control_unit
    import fp_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ALIGN = MAX_ALIGN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       operacao,
    input  logic [7:0] saida_registrador,
    input  logic [7:0] tamanhoShift,
    input  logic       directionShift,
    input  logic       overflow,
    output logic       soma_multiplica_small_ula,
    output logic       soma_multiplica_big_ula,
    output logic       subtrador_big_ula,
    output logic [4:0] tamanho,
    output logic [4:0] tamanho2,
    output logic [7:0] tamanho3,
    output logic       decisor_mux_expoente_escolhido,
    output logic       decisor_mux_saida_big_ula,
    output logic       decisor_shift_right_left,
    output logic       subtrador_Somador_subtrador,
    output logic       load,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    logic       op_q, op_d;
    logic [7:0] align_sat;

    logic       sm_small_d, sm_big_d, sub_big_d;
    logic [4:0] tamanho_d, tamanho2_d;
    logic [7:0] tamanho3_d;
    logic       mux_exp_d, mux_saida_d, shift_dir_d, som_sub_d;
    logic       load_d, busy_d, done_d;

    assign align_sat = (saida_registrador > 8'(MAX_ALIGN)) ? 8'(MAX_ALIGN) : saida_registrador;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q                        <= S_IDLE;
            op_q                           <= OP_MULT;
            soma_multiplica_small_ula      <= 1'b0;
            soma_multiplica_big_ula        <= 1'b0;
            subtrador_big_ula              <= 1'b0;
            tamanho                        <= 5'd0;
            tamanho2                       <= 5'd0;
            tamanho3                       <= 8'd0;
            decisor_mux_expoente_escolhido <= 1'b0;
            decisor_mux_saida_big_ula      <= 1'b0;
            decisor_shift_right_left       <= 1'b0;
            subtrador_Somador_subtrador    <= 1'b0;
            load                           <= 1'b0;
            busy                           <= 1'b0;
            done                           <= 1'b0;
        end else begin
            state_q                        <= state_d;
            op_q                           <= op_d;
            soma_multiplica_small_ula      <= sm_small_d;
            soma_multiplica_big_ula        <= sm_big_d;
            subtrador_big_ula              <= sub_big_d;
            tamanho                        <= tamanho_d;
            tamanho2                       <= tamanho2_d;
            tamanho3                       <= tamanho3_d;
            decisor_mux_expoente_escolhido <= mux_exp_d;
            decisor_mux_saida_big_ula      <= mux_saida_d;
            decisor_shift_right_left       <= shift_dir_d;
            subtrador_Somador_subtrador    <= som_sub_d;
            load                           <= load_d;
            busy                           <= busy_d;
            done                           <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = operacao;
                    state_d = S_EXP;
                end
            end
            S_EXP:     state_d = S_ALIGN;
            S_ALIGN:   state_d = S_BIG;
            S_BIG:     state_d = (op_q == OP_SOMA) ? S_LD_EXP : S_DONE;
            S_LD_EXP:  state_d = S_NORM;
            S_NORM:    state_d = S_LD_NORM;
            S_LD_NORM: state_d = S_RND;
            S_RND:     state_d = S_LD_RND;
            S_LD_RND:  state_d = S_CHK;
            S_CHK:     state_d = overflow ? S_LD_OVF : S_DONE;
            S_LD_OVF:  state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Decoded on the state being entered; anything not assigned holds its last value.
    always_comb begin
        sm_small_d  = soma_multiplica_small_ula;
        sm_big_d    = soma_multiplica_big_ula;
        sub_big_d   = subtrador_big_ula;
        tamanho_d   = tamanho;
        tamanho2_d  = tamanho2;
        tamanho3_d  = tamanho3;
        mux_exp_d   = decisor_mux_expoente_escolhido;
        mux_saida_d = decisor_mux_saida_big_ula;
        shift_dir_d = decisor_shift_right_left;
        som_sub_d   = subtrador_Somador_subtrador;
        load_d      = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE);
        unique case (state_d)
            S_EXP: begin
                sm_small_d = operacao;
                sm_big_d   = operacao;
            end
            S_ALIGN: begin
                tamanho_d = 5'(align_sat);
                sub_big_d = 1'b0;
            end
            S_LD_EXP: begin
                mux_exp_d  = 1'b0;
                som_sub_d  = 1'b0;
                tamanho3_d = saida_registrador;
                load_d     = 1'b1;
            end
            S_NORM: begin
                tamanho3_d  = sub_clamp(tamanhoShift, directionShift);
                tamanho2_d  = 5'(sub_clamp({3'd0, tamanhoShift[4:0]}, directionShift));
                mux_exp_d   = 1'b1;
                som_sub_d   = 1'b1;
                mux_saida_d = 1'b0;
                shift_dir_d = directionShift ? SHIFT_LEFT : SHIFT_RIGHT;
            end
            S_RND: begin
                som_sub_d   = 1'b0;
                tamanho3_d  = 8'd1;
                tamanho2_d  = 5'd1;
                shift_dir_d = SHIFT_RIGHT;
            end
            S_LD_NORM, S_LD_RND: load_d = 1'b1;
            S_LD_OVF: begin
                mux_saida_d = 1'b1;
                shift_dir_d = SHIFT_RIGHT;
                tamanho2_d  = 5'd1;
                mux_exp_d   = 1'b1;
                som_sub_d   = 1'b0;
                tamanho3_d  = 8'd1;
                load_d      = 1'b1;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_control_unit.sv
// Self-checking bench for fp_control_unit: directed and random operations against a
// cycle-count/result model derived from the operation rules.
module tb_fp_control_unit;

    logic       clk = 1'b0;
    logic       rst_n, start, operacao, directionShift, overflow;
    logic [7:0] saida_registrador, tamanhoShift;
    logic       sm_small, sm_big, sub_big, mux_exp, mux_saida, shift_dir, som_sub;
    logic       load, busy, done;
    logic [4:0] tamanho, tamanho2;
    logic [7:0] tamanho3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_control_unit dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .start                          (start),
        .operacao                       (operacao),
        .saida_registrador              (saida_registrador),
        .tamanhoShift                   (tamanhoShift),
        .directionShift                 (directionShift),
        .overflow                       (overflow),
        .soma_multiplica_small_ula      (sm_small),
        .soma_multiplica_big_ula        (sm_big),
        .subtrador_big_ula              (sub_big),
        .tamanho                        (tamanho),
        .tamanho2                       (tamanho2),
        .tamanho3                       (tamanho3),
        .decisor_mux_expoente_escolhido (mux_exp),
        .decisor_mux_saida_big_ula      (mux_saida),
        .decisor_shift_right_left       (shift_dir),
        .subtrador_Somador_subtrador    (som_sub),
        .load                           (load),
        .busy                           (busy),
        .done                           (done)
    );

    typedef struct {
        int op, sr, ts, dir, ovf, glitch;
        int lat, tam, t2n, t3n;
    } vec_t;

    // Expected values of the held control outputs after the last completed operation.
    int m_sm, m_tam, m_sub_big, m_t2, m_t3, m_mexp, m_msaida, m_sdir, m_som_sub;

    function automatic int model_lat(int op, int ovf);
        return op ? (ovf ? 11 : 10) : 4;
    endfunction

    function automatic int model_tam(int sr);
        return (sr > 26) ? 26 : sr;
    endfunction

    function automatic int model_sub(int a, int b);
        return (a >= b) ? a - b : 0;
    endfunction

    function automatic bit model_load(vec_t v, int c);
        return v.op != 0 && (c == 4 || c == 6 || c == 8 || (v.ovf != 0 && c == 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sm = 0; m_tam = 0; m_sub_big = 0; m_t2 = 0; m_t3 = 0;
        m_mexp = 0; m_msaida = 0; m_sdir = 0; m_som_sub = 0;
    endtask

    task automatic model_apply(vec_t v);
        m_sm      = v.op;
        m_tam     = model_tam(v.sr);
        m_sub_big = 0;
        if (v.op != 0) begin
            m_mexp = 1; m_som_sub = 0; m_t3 = 1; m_t2 = 1; m_sdir = 0; m_msaida = v.ovf;
        end
    endtask

    task automatic check_held(string tag);
        chk({tag, ".sm_small"}, 32'(sm_small), m_sm);
        chk({tag, ".sm_big"}, 32'(sm_big), m_sm);
        chk({tag, ".sub_big"}, 32'(sub_big), m_sub_big);
        chk({tag, ".tamanho"}, 32'(tamanho), m_tam);
        chk({tag, ".tamanho2"}, 32'(tamanho2), m_t2);
        chk({tag, ".tamanho3"}, 32'(tamanho3), m_t3);
        chk({tag, ".mux_exp"}, 32'(mux_exp), m_mexp);
        chk({tag, ".mux_saida"}, 32'(mux_saida), m_msaida);
        chk({tag, ".shift_dir"}, 32'(shift_dir), m_sdir);
        chk({tag, ".som_sub"}, 32'(som_sub), m_som_sub);
    endtask

    task automatic drive_inputs(vec_t v);
        operacao          = v.op[0];
        saida_registrador = v.sr[7:0];
        tamanhoShift      = v.ts[7:0];
        directionShift    = v.dir[0];
        overflow          = v.ovf[0];
    endtask

    task automatic run_op(vec_t v, string tag);
        drive_inputs(v);
        start = 1'b1;
        tick();
        for (int c = 1; c <= v.lat + 1; c++) begin
            start = (v.glitch != 0 && (c == 2 || c == 3));
            chk({tag, ".busy"}, 32'(busy), 32'(c <= v.lat));
            chk({tag, ".load"}, 32'(load), 32'(model_load(v, c)));
            chk({tag, ".done"}, 32'(done), 32'(c == v.lat));
            if (c == 1) chk({tag, ".sm_entry"}, 32'(sm_small & sm_big), v.op);
            if (c == 2) chk({tag, ".align"}, 32'(tamanho), v.tam);
            if (v.op != 0 && c == 4) chk({tag, ".t3_exp"}, 32'(tamanho3), v.sr);
            if (v.op != 0 && c == 5) begin
                chk({tag, ".t3_norm"}, 32'(tamanho3), v.t3n);
                chk({tag, ".t2_norm"}, 32'(tamanho2), v.t2n);
                chk({tag, ".dir_norm"}, 32'(shift_dir), v.dir);
            end
            if (c == v.lat) begin
                model_apply(v);
                check_held({tag, ".final"});
            end
            tick();
        end
        start = 1'b0;
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        rst_n = 1'b0; start = 1'b0; operacao = 1'b0; saida_registrador = '0;
        tamanhoShift = '0; directionShift = 1'b0; overflow = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset.busy", 32'(busy), 0);
        chk("reset.load", 32'(load), 0);
        chk("reset.done", 32'(done), 0);
        check_held("reset");
        rst_n = 1'b1;
        tick();

        //           op  sr   ts  dir ovf gl  lat tam t2n t3n
        vecs.push_back('{1, 1,   1,   0, 0, 0, 10, 1,  1,  1});
        vecs.push_back('{1, 1,   1,   0, 1, 0, 11, 1,  1,  1});
        vecs.push_back('{1, 40,  0,   1, 0, 0, 10, 26, 0,  0});
        vecs.push_back('{0, 5,   9,   1, 1, 0, 4,  5,  0,  0});
        vecs.push_back('{1, 200, 35,  1, 0, 1, 10, 26, 2,  34});
        vecs.push_back('{0, 26,  3,   0, 0, 1, 4,  26, 0,  0});
        vecs.push_back('{1, 25,  64,  1, 1, 0, 11, 25, 0,  63});
        for (int i = 0; i < 20; i++) begin
            v.op  = int'($urandom_range(0, 1));
            v.sr  = int'($urandom_range(0, 255));
            v.ts  = int'($urandom_range(0, 255));
            v.dir = int'($urandom_range(0, 1));
            v.ovf = int'($urandom_range(0, 1));
            v.glitch = ($urandom_range(0, 3) == 0) ? 1 : 0;
            v.lat = model_lat(v.op, v.ovf);
            v.tam = model_tam(v.sr);
            v.t3n = model_sub(v.ts, v.dir);
            v.t2n = model_sub(v.ts % 32, v.dir);
            vecs.push_back(v);
        end
        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Start held high across done: restart two cycles after the done pulse.
        v = vecs[0];
        drive_inputs(v);
        start = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) chk("held.done1", 32'(done), 1);
            if (c == 11) chk("held.idle", 32'(busy), 0);
            tick();
        end
        chk("held.restart", 32'(busy), 1);
        start = 1'b0;
        for (int c = 12; c <= 21; c++) begin
            chk("held.done2", 32'(done), 32'(c == 21));
            tick();
        end
        model_apply(v);
        check_held("held");

        // Reset asserted while in the normalisation state.
        drive_inputs(vecs[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("midrst.pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        model_reset();
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.load", 32'(load), 0);
        chk("midrst.done", 32'(done), 0);
        check_held("midrst");
        rst_n = 1'b1;
        tick();
        run_op(vecs[3], "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_control_unit.md
Name: fp_control_unit

Overview:
- Moore FSM that sequences the floating-point Datapath through one addition or one multiplication.
- Sits directly upstream of Datapath and drives every control input on it.
- Reads back the Datapath status lines saida_registrador, tamanhoShift, directionShift and overflow.
- Replaces per-cycle manual stimulus; a single start pulse produces a complete, rounded result.

Parameters:
- MAX_ALIGN, 26, saturation value for the alignment shift amount (width of the big ULA data path).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in S_IDLE
- operacao  in  1  1 = soma, 0 = multiplicacao; latched with start
- saida_registrador  in  8  exponent difference/sum from Datapath
- tamanhoShift  in  8  normalisation shift amount from Datapath
- directionShift  in  1  normalisation direction from Datapath (1 = left)
- overflow  in  1  rounding overflow flag from Datapath
- soma_multiplica_small_ula  out  1  1 = soma, 0 = multiplica
- soma_multiplica_big_ula  out  1  1 = soma, 0 = multiplica
- subtrador_big_ula  out  1  0 = add, 1 = subtract
- tamanho  out  5  alignment shift amount
- tamanho2  out  5  fraction shift amount
- tamanho3  out  8  exponent inc/dec amount
- decisor_mux_expoente_escolhido  out  1  exponent mux select
- decisor_mux_saida_big_ula  out  1  0 = big ULA, 1 = rounding path
- decisor_shift_right_left  out  1  1 = left, 0 = right
- subtrador_Somador_subtrador  out  1  0 = add, 1 = subtract
- load  out  1  Datapath register load strobe
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Output registration: all outputs registered.
- Reset (rst_n = 0 at an edge): state S_IDLE; every output 0. Applies mid-operation too; any in-flight load is dropped.
- Transitions: one state per cycle unless stated. Values listed are output values during that state.
- S_IDLE:
  - On start = 1: latch operacao into op_q.
  - Set both soma_multiplica_* = operacao.
  - Go to S_EXP.
  - When not in S_IDLE, start is ignored.
- S_EXP: wait one cycle for the small ULA result. Go to S_ALIGN.
- S_ALIGN:
  - tamanho = min(saida_registrador, MAX_ALIGN), truncated to 5 bits.
  - subtrador_big_ula = 0.
  - Go to S_BIG.
- S_BIG: hold all values. If op_q = 0, go to S_DONE; otherwise go to S_LD_EXP.
- S_LD_EXP:
  - decisor_mux_expoente_escolhido = 0, subtrador_Somador_subtrador = 0.
  - tamanho3 = saida_registrador.
  - load = 1.
  - Go to S_NORM.
- S_NORM:
  - load = 0. Sample tamanhoShift/directionShift.
  - tamanho3 = tamanhoShift − directionShift.
  - tamanho2 = tamanhoShift[4:0] − directionShift.
  - Both subtractions clamp at 0 (no wrap).
  - mux_expoente = 1, Somador_subtrador = 1.
  - mux_saida = 0, shift_right_left = directionShift.
  - Go to S_LD_NORM.
- S_LD_NORM: load = 1. Go to S_RND.
- S_RND:
  - load = 0.
  - subtrador_Somador_subtrador = 0, tamanho3 = 1, tamanho2 = 1, shift_right_left = 0.
  - Go to S_LD_RND.
- S_LD_RND: load = 1. Go to S_CHK.
- S_CHK:
  - load = 0. Sample overflow.
  - If overflow = 1, go to S_LD_OVF; otherwise go to S_DONE.
- S_LD_OVF:
  - mux_saida = 1, shift_right_left = 0, tamanho2 = 1.
  - mux_expoente = 1, Somador_subtrador = 0, tamanho3 = 1.
  - load = 1.
  - Go to S_DONE.
- S_DONE: load = 0, done = 1 for exactly one cycle. Go to S_IDLE.
- Latency, counted from the edge sampling start to the cycle with done high:
  - soma without overflow: 10 cycles.
  - soma with overflow: 11 cycles.
  - multiplicacao: 4 cycles.
- load is never high in two consecutive cycles.
- start held high: a new operation begins only after S_DONE → S_IDLE, at the earliest 1 cycle after done.
- Unused control outputs hold their last value between states. They return to 0 only on reset.

Decomposition:
- Package fp_ctrl_pkg holds:
  - state enum (S_IDLE … S_DONE, 4-bit encoding)
  - OP_SOMA = 1'b1, OP_MULT = 1'b0
  - SHIFT_LEFT = 1'b1, SHIFT_RIGHT = 1'b0
  - MAX_ALIGN default
- No sub-module; a single FSM with a registered output decode.

Test Plan:
- Reset mid-operation: start soma, assert rst_n = 0 in S_NORM → next cycle busy = 0, load = 0, all outputs 0, state S_IDLE.
- Soma without overflow: operacao = 1, saida_registrador = 1, tamanhoShift = 1, directionShift = 0, overflow = 0.
  - Expect tamanho = 1 in S_ALIGN.
  - Expect load high on cycles 4, 6, 8.
  - Expect done on cycle 10 with tamanho3 = 1, tamanho2 = 1.
- Soma with overflow = 1 in S_CHK: expect extra load on cycle 10 with mux_saida = 1, tamanho3 = 1; done on cycle 11.
- Alignment saturation and clamp:
  - saida_registrador = 40 → tamanho = 26.
  - tamanhoShift = 0, directionShift = 1 → tamanho2 = 0, tamanho3 = 0 (clamp).
- Multiplicacao: operacao = 0 → both soma_multiplica_* = 0, no load pulses, done on cycle 4.
- Start handling:
  - start asserted while busy → ignored; only one done.
  - start held high across done → second operation begins the cycle after S_IDLE is re-entered.
